ram_nra_1ws_dff: RTL and testbench

Parametrised flip-flop RAM with one synchronous write port and NUM_RD_PORTS independent asynchronous read ports. Supports per-byte write masking and a hardware clear sequencer that zeroes the array after reset or on request. Write-to-read forwarding is optional. Used as the register-file and small-buffer storage primitive in the GCN datapath wherever more than one consumer reads the same array in a cycle.

---
 rtl/ram_nra_1ws_dff.sv | 161 ++++++++++++++++
 tb/tb_ram_nra_1ws_dff.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_nra_1ws_dff.sv
// Flip-flop RAM: one synchronous byte-masked write port, NUM_RD_PORTS
// asynchronous read ports, and a clear sequencer that zeroes the array.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cs_n, we_n          active-low chip select / write enable
//   wr_addr, wr_mask    write address and per-byte enables
//   data_in             write data
//   clear_req           pulse that (re)starts a clear sweep
//   rd_addr             packed read addresses, port p in slice p
//   data_out            packed read data, combinational
//   busy                high while the clear sweep runs
//   err                 sticky error flag, cleared only by reset
//
// Optional feature: define KW_RAM_BYPASS_EN to forward an in-flight
// write to any read port addressing the same word.
module ram_nra_1ws_dff #(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int DEPTH        = 64,
    parameter int NUM_RD_PORTS = 2,
    parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               cs_n,
    input  logic                               we_n,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_mask,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               clear_req,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] data_out,
    output logic                               busy,
    output logic                               err
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  wr_req;
    logic                  wr_in_range;
    logic                  wr_en;
    logic                  clr_last;
    logic [DATA_WIDTH-1:0] wr_merged;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (mask[b]) begin
                res[b*BYTE_WIDTH +: BYTE_WIDTH] =
                    new_word[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    assign wr_req      = !cs_n && !we_n;
    // Widen before comparing so a power-of-2 DEPTH does not
    // produce a constant-result comparison.
    assign wr_in_range = 32'(wr_addr) < 32'(DEPTH);
    assign wr_en       = wr_req && wr_in_range && (state == IDLE);
    assign clr_last    = (clr_addr == LAST_ADDR);
    // Only meaningful when wr_in_range; otherwise never consumed.
    assign wr_merged   = merge_bytes(mem[wr_addr], data_in, wr_mask);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a clear request always (re)enters CLEAR
    always_comb begin
        state_next = state;
        unique case (state)
            CLEAR: if (clr_last) state_next = IDLE;
            IDLE:  state_next = IDLE;
            default: state_next = CLEAR;
        endcase
        if (clear_req) begin
            state_next = CLEAR;
        end
    end

    // Output logic
    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clock) begin
        if (reset || clear_req) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (wr_req && (state == CLEAR || !wr_in_range)) begin
            err <= 1'b1;
        end
    end

    // Array storage has no reset; the sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (wr_en) begin
                mem[wr_addr] <= wr_merged;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] word;
        logic                  hit;

        assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef KW_RAM_BYPASS_EN
        assign hit = wr_en && (addr == wr_addr);
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            word = '0;
            if (!busy && 32'(addr) < 32'(DEPTH)) begin
                word = hit ? wr_merged : mem[addr];
            end
        end

        assign data_out[p*DATA_WIDTH +: DATA_WIDTH] = word;
    end

endmodule

// File: tb/tb_ram_nra_1ws_dff.sv
// Self-checking bench for ram_nra_1ws_dff (DEPTH=48, 2 read ports).
// Behavioural model tracks words, remaining clear cycles and err.
module tb_ram_nra_1ws_dff;

    localparam int DW = 32;
    localparam int BW = 8;
    localparam int D  = 48;
    localparam int NP = 2;
    localparam int AW = 6;
    localparam int NB = DW / BW;

    logic               clock = 1'b0;
    logic               reset;
    logic               cs_n;
    logic               we_n;
    logic [AW-1:0]      wr_addr;
    logic [NB-1:0]      wr_mask;
    logic [DW-1:0]      data_in;
    logic               clear_req;
    logic [NP*AW-1:0]   rd_addr;
    logic [NP*DW-1:0]   data_out;
    logic               busy;
    logic               err;

    logic [DW-1:0] model [D];
    int            busy_cnt;
    bit            err_m;
    int            passed = 0;
    int            total  = 0;

    ram_nra_1ws_dff #(
        .DATA_WIDTH(DW),
        .BYTE_WIDTH(BW),
        .DEPTH(D),
        .NUM_RD_PORTS(NP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cs_n(cs_n),
        .we_n(we_n),
        .wr_addr(wr_addr),
        .wr_mask(wr_mask),
        .data_in(data_in),
        .clear_req(clear_req),
        .rd_addr(rd_addr),
        .data_out(data_out),
        .busy(busy),
        .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mrg(
        input logic [DW-1:0] o,
        input logic [DW-1:0] d,
        input logic [NB-1:0] m
    );
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < NB; b++)
            if (m[b]) r[b*BW +: BW] = d[b*BW +: BW];
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (busy_cnt > 0 || a >= D) return '0;
`ifdef KW_RAM_BYPASS_EN
        if (!cs_n && !we_n && int'(wr_addr) < D && a == int'(wr_addr))
            return mrg(model[a], data_in, wr_mask);
`endif
        return model[a];
    endfunction

    function automatic logic [DW-1:0] port(input int p);
        return data_out[p*DW +: DW];
    endfunction

    function automatic int raddr(input int p);
        return int'(rd_addr[p*AW +: AW]);
    endfunction

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle_inputs();
        reset = 0; cs_n = 1; we_n = 1; clear_req = 0;
        wr_mask = '0; data_in = '0; wr_addr = '0;
    endtask

    task automatic drive_wr(input int a, input logic [NB-1:0] m,
                            input logic [DW-1:0] d);
        cs_n = 0; we_n = 0; wr_addr = AW'(a); wr_mask = m; data_in = d;
    endtask

    // One clock edge; model applies the rules to the sampled inputs.
    task automatic step();
        bit wr;
        @(posedge clock);
        wr = !cs_n && !we_n;
        if (reset) begin
            busy_cnt = D;
            err_m = 0;
        end else if (busy_cnt > 0) begin
            if (wr) err_m = 1;
            model[D - busy_cnt] = '0;
            busy_cnt = clear_req ? D : busy_cnt - 1;
        end else begin
            if (wr) begin
                if (int'(wr_addr) < D)
                    model[wr_addr] = mrg(model[wr_addr], data_in, wr_mask);
                else
                    err_m = 1;
            end
            if (clear_req) busy_cnt = D;
        end
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 2 * D + 10) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            $display("FAIL wait_idle: busy=%b after %0d cycles", busy, n);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        idle_inputs();
        reset = 1;
        set_rd(0, 3); set_rd(1, 40);
        step();
        reset = 0;
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy);
        else passed++;
        total++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else passed++;
        total++;
        if (data_out !== '0) $display("FAIL reset_dout: got %h want 0", data_out);
        else passed++;
        while (busy === 1'b1 && n < 3 * D) begin
            step();
            n++;
        end
        total++;
        if (n != D) $display("FAIL clear_len: got %0d want %0d", n, D);
        else passed++;
        for (int a = 0; a < D; a++) begin
            set_rd(0, a); set_rd(1, D - 1 - a);
            #1;
            for (int p = 0; p < NP; p++) begin
                total++;
                if (port(p) !== '0)
                    $display("FAIL swept_zero p%0d a%0d: got %h want 0",
                             p, raddr(p), port(p));
                else passed++;
            end
        end
    endtask

    task automatic test_mask_write();
        idle_inputs();
        drive_wr(5, 4'b1111, 32'hDEADBEEF);
        step();
        drive_wr(5, 4'b0001, 32'h000000AA);
        step();
        idle_inputs();
        set_rd(0, 5); set_rd(1, 5);
        #1;
        for (int p = 0; p < NP; p++) begin
            total++;
            if (port(p) !== 32'hDEADBEAA || port(p) !== exp_rd(5))
                $display("FAIL mask_write p%0d: got %h want DEADBEAA",
                         p, port(p));
            else passed++;
        end
        drive_wr(9, 4'b0000, 32'hFFFFFFFF);
        step();
        idle_inputs();
        set_rd(0, 9);
        #1;
        total++;
        if (port(0) !== '0) $display("FAIL mask_zero: got %h want 0", port(0));
        else passed++;
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        idle_inputs();
        drive_wr(7, 4'b1111, 32'hAABBCCDD);
        drive_wr(8, 4'b1111, 32'h01020304);
        step();
        drive_wr(7, 4'b1111, 32'hAABBCCDD);
        step();
        drive_wr(7, 4'b0011, 32'h12345678);
        set_rd(0, 7); set_rd(1, 8);
        #1;
`ifdef KW_RAM_BYPASS_EN
        want = 32'hAABB5678;
`else
        want = 32'hAABBCCDD;
`endif
        total++;
        if (port(0) !== want)
            $display("FAIL bypass_same: got %h want %h", port(0), want);
        else passed++;
        total++;
        if (port(1) !== 32'h01020304)
            $display("FAIL bypass_other: got %h want 01020304", port(1));
        else passed++;
        step();
        idle_inputs();
        #1;
        total++;
        if (port(0) !== 32'hAABB5678)
            $display("FAIL bypass_after: got %h want AABB5678", port(0));
        else passed++;
    endtask

    task automatic test_out_of_range();
        idle_inputs();
        total++;
        if (err !== 1'b0) $display("FAIL oor_pre_err: got %b want 0", err);
        else passed++;
        drive_wr(50, 4'b1111, $urandom);
        step();
        idle_inputs();
        total++;
        if (err !== 1'b1) $display("FAIL oor_err: got %b want 1", err);
        else passed++;
        set_rd(1, 50);
        for (int a = 0; a < D; a++) begin
            set_rd(0, a);
            #1;
            total++;
            if (port(0) !== model[a])
                $display("FAIL oor_intact a%0d: got %h want %h",
                         a, port(0), model[a]);
            else passed++;
        end
        total++;
        if (port(1) !== '0) $display("FAIL oor_read: got %h want 0", port(1));
        else passed++;
    endtask

    task automatic test_write_during_busy();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        total++;
        if (err !== 1'b0) $display("FAIL wdb_reset_err: got %b want 0", err);
        else passed++;
        repeat (9) step();
        drive_wr(3, 4'b1111, 32'hFFFFFFFF);
        step();
        idle_inputs();
        total++;
        if (err !== 1'b1) $display("FAIL wdb_err: got %b want 1", err);
        else passed++;
        wait_idle();
        set_rd(0, 3);
        #1;
        total++;
        if (port(0) !== '0 || port(0) !== exp_rd(3))
            $display("FAIL wdb_dropped: got %h want 0", port(0));
        else passed++;
        clear_req = 1;
        step();
        clear_req = 0;
        total++;
        if (err !== 1'b1 || busy !== 1'b1)
            $display("FAIL wdb_clr_keeps_err: got err=%b busy=%b want 1 1",
                     err, busy);
        else passed++;
        wait_idle();
        total++;
        if (err !== 1'b1) $display("FAIL wdb_err_sticky: got %b want 1", err);
        else passed++;
        reset = 1;
        step();
        reset = 0;
        total++;
        if (err !== 1'b0) $display("FAIL wdb_err_clr: got %b want 0", err);
        else passed++;
        wait_idle();
    endtask

    task automatic test_clear_restart();
        int n = 0;
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        repeat (20) step();
        clear_req = 1;
        step();
        clear_req = 0;
        while (busy === 1'b1 && n < 3 * D) begin
            step();
            n++;
        end
        total++;
        if (n != D) $display("FAIL restart_len: got %0d want %0d", n, D);
        else passed++;
        drive_wr(3, 4'b1111, 32'hC0FFEE11);
        step();
        idle_inputs();
        set_rd(0, 3); set_rd(1, 3);
        #1;
        total++;
        if (port(0) !== 32'hC0FFEE11 || port(1) !== 32'hC0FFEE11)
            $display("FAIL restart_wr: got %h/%h want C0FFEE11",
                     port(0), port(1));
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            clear_req = ($urandom_range(0, 149) == 0);
            cs_n      = $urandom_range(0, 2) == 0;
            we_n      = $urandom_range(0, 2) == 0;
            wr_addr   = AW'($urandom_range(0, 63));
            wr_mask   = NB'($urandom);
            data_in   = $urandom;
            set_rd(0, $urandom_range(0, 1) ? int'(wr_addr)
                                            : $urandom_range(0, 63));
            set_rd(1, $urandom_range(0, 63));
            #1;
            for (int p = 0; p < NP; p++) begin
                total++;
                if (port(p) !== exp_rd(raddr(p)))
                    $display("FAIL rnd_rd c%0d p%0d a%0d: got %h want %h",
                             c, p, raddr(p), port(p), exp_rd(raddr(p)));
                else passed++;
            end
            total++;
            if (busy !== (busy_cnt > 0) || err !== err_m)
                $display("FAIL rnd_flags c%0d: got busy=%b err=%b want %b %b",
                         c, busy, err, busy_cnt > 0, err_m);
            else passed++;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        busy_cnt = D;
        err_m = 0;
        for (int a = 0; a < D; a++) model[a] = '0;
        rd_addr = '0;
        idle_inputs();
        test_reset();
        test_mask_write();
        test_bypass();
        test_out_of_range();
        test_write_during_busy();
        test_clear_restart();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
